reg_file_arb: RTL and testbench

Two-requester arbiter and sequencer for the 2-entry x 16-bit register file. Requesters issue single-word reads and writes over valid/ready handshakes. The block grants one request per cycle with round-robin priority and keeps a shadow copy of the file contents that drives the file's full-vector write input. It returns a registered response one cycle after acceptance and forwards data across the one-cycle write-to-file delay.

---
 rtl/reg_file_arb.sv | 128 ++++++++++++
 tb/tb_reg_file_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arb.sv
// Round-robin arbiter and sequencer in front of a 2-entry register file.
// Keeps a shadow copy of the file and forwards it across the one-cycle write-to-file delay.
module reg_file_arb #(
    parameter int DATA_W = 16,
    parameter int N_REGS = 2,
    parameter int ADDR_W = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic                     req0_write,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_wdata,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic                     req1_write,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_wdata,
    output logic                     req1_ready,
    output logic                     rsp0_valid,
    output logic [DATA_W-1:0]        rsp0_data,
    output logic                     rsp0_err,
    output logic                     rsp1_valid,
    output logic [DATA_W-1:0]        rsp1_data,
    output logic                     rsp1_err,
    output logic [ADDR_W-1:0]        rf_raddr,
    output logic [N_REGS*DATA_W-1:0] rf_wvec,
    input  logic [DATA_W-1:0]        rf_rdata
);

    // ptr_q names the requester that wins the next contention
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] shadow_q [N_REGS];
    logic [DATA_W-1:0] shadow_d [N_REGS];
    logic              fwd_vld_q, fwd_vld_d;
    logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic              rsp0_err_q, rsp0_err_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
    logic              rsp1_err_q, rsp1_err_d;

    logic              gnt0, gnt1, acc;
    logic              sel_write, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, sel_shadow, rd_data, rsp_data;

    always_comb begin
        gnt0      = req0_valid & (~req1_valid | ~ptr_q);
        gnt1      = req1_valid & (~req0_valid | ptr_q);
        acc       = gnt0 | gnt1;
        sel_write = gnt1 ? req1_write : req0_write;
        sel_addr  = gnt1 ? req1_addr  : req0_addr;
        sel_wdata = gnt1 ? req1_wdata : req0_wdata;
        in_range  = sel_addr < ADDR_W'(N_REGS);

        sel_shadow = '0;
        shadow_d   = shadow_q;
        for (int i = 0; i < N_REGS; i++) begin
            if (sel_addr == ADDR_W'(i)) begin
                sel_shadow = shadow_q[i];
                if (acc && sel_write)
                    shadow_d[i] = sel_wdata;
            end
        end

        // the file still holds the old value one cycle after a write; use the shadow
        rd_data  = (fwd_vld_q && fwd_addr_q == sel_addr) ? sel_shadow : rf_rdata;
        rsp_data = (acc && !sel_write && in_range) ? rd_data : '0;

        rf_raddr   = (acc && in_range) ? sel_addr : '0;
        fwd_vld_d  = acc & sel_write & in_range;
        fwd_addr_d = sel_addr;
        ptr_d      = acc ? gnt0 : ptr_q;

        rsp0_valid_d = gnt0;
        rsp0_data_d  = gnt0 ? rsp_data : '0;
        rsp0_err_d   = gnt0 & ~in_range;
        rsp1_valid_d = gnt1;
        rsp1_data_d  = gnt1 ? rsp_data : '0;
        rsp1_err_d   = gnt1 & ~in_range;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q        <= 1'b0;
            fwd_vld_q    <= 1'b0;
            fwd_addr_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_err_q   <= 1'b0;
            for (int i = 0; i < N_REGS; i++)
                shadow_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            fwd_vld_q    <= fwd_vld_d;
            fwd_addr_q   <= fwd_addr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_err_q   <= rsp1_err_d;
            for (int i = 0; i < N_REGS; i++)
                shadow_q[i] <= shadow_d[i];
        end
    end

    always_comb begin
        rf_wvec = '0;
        for (int i = 0; i < N_REGS; i++)
            rf_wvec[DATA_W*(N_REGS-1-i) +: DATA_W] = shadow_q[i];
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_reg_file_arb.sv
// Bench for reg_file_arb: directed scenarios plus random traffic against an
// architectural memory model and a behavioural register file.
module tb_reg_file_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        v [2];
    logic        w [2];
    logic [2:0]  a [2];
    logic [15:0] d [2];
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [15:0] rsp0_data, rsp1_data, rf_rdata;
    logic [2:0]  rf_raddr;
    logic [31:0] rf_wvec;

    // register file: captures r_in every edge, cleared with the block
    logic [15:0] rf_mem [2];

    // architectural model
    logic [15:0] mem [2];
    int          prio;
    int          last_g;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_mem[0] <= '0;
            rf_mem[1] <= '0;
        end else begin
            rf_mem[0] <= rf_wvec[31:16];
            rf_mem[1] <= rf_wvec[15:0];
        end
    end
    assign rf_rdata = (rf_raddr < 3'd2) ? rf_mem[rf_raddr[0]] : 16'hDEAD;

    reg_file_arb dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (v[0]),
        .req0_write (w[0]),
        .req0_addr  (a[0]),
        .req0_wdata (d[0]),
        .req0_ready (req0_ready),
        .req1_valid (v[1]),
        .req1_write (w[1]),
        .req1_addr  (a[1]),
        .req1_wdata (d[1]),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .rf_raddr   (rf_raddr),
        .rf_wvec    (rf_wvec),
        .rf_rdata   (rf_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        mem[0] = '0;
        mem[1] = '0;
        prio   = 0;
        last_g = -1;
    endtask

    task automatic set_req(input int r, input logic vv, input logic ww,
                           input logic [2:0] aa, input logic [15:0] dd);
        v[r] = vv; w[r] = ww; a[r] = aa; d[r] = dd;
    endtask

    task automatic idle();
        v[0] = 1'b0;
        v[1] = 1'b0;
    endtask

    // one clock cycle: check combinational grant, then the registered response
    task automatic step();
        int          g;
        logic [15:0] exp_data;
        logic        exp_err;
        logic        rd;
        @(negedge clock);
        if (v[0] && v[1]) g = prio;
        else if (v[0])    g = 0;
        else if (v[1])    g = 1;
        else              g = -1;
        check("ready0", {31'd0, req0_ready}, {31'd0, g == 0});
        check("ready1", {31'd0, req1_ready}, {31'd0, g == 1});
        exp_data = '0;
        exp_err  = 1'b0;
        rd       = 1'b0;
        if (g < 0) begin
            check("raddr_idle", {29'd0, rf_raddr}, 32'd0);
        end else begin
            exp_err = (a[g] >= 3'd2);
            rd      = !w[g];
            if (exp_err)
                check("raddr_oor", {29'd0, rf_raddr}, 32'd0);
            else if (rd) begin
                check("raddr_rd", {29'd0, rf_raddr}, {29'd0, a[g]});
                exp_data = mem[a[g][0]];
            end
        end
        @(posedge clock);
        #1;
        if (g >= 0) begin
            if (w[g] && !exp_err)
                mem[a[g][0]] = d[g];
            prio = 1 - g;
        end
        last_g = g;
        check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, g == 0});
        check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, g == 1});
        if (g == 0) begin
            check("rsp0_data", {16'd0, rsp0_data}, {16'd0, exp_data});
            check("rsp0_err", {31'd0, rsp0_err}, {31'd0, exp_err});
        end else if (g == 1) begin
            check("rsp1_data", {16'd0, rsp1_data}, {16'd0, exp_data});
            check("rsp1_err", {31'd0, rsp1_err}, {31'd0, exp_err});
        end
        check("rf_wvec", rf_wvec, {mem[0], mem[1]});
    endtask

    task automatic rand_req(input int r);
        logic [2:0] ad;
        ad = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
        set_req(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ad, 16'($urandom));
    endtask

    initial begin
        int gseq [$];
        model_reset();
        idle();
        set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
        #22 reset = 1'b1;
        #1;
        check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("rst_rsp0_data", {16'd0, rsp0_data}, 32'd0);
        check("rst_rsp1_err", {31'd0, rsp1_err}, 32'd0);
        check("rst_wvec", rf_wvec, 32'd0);

        // write A5A5 to entry 0, then idle
        set_req(0, 1'b1, 1'b1, 3'd0, 16'hA5A5);
        step();
        check("wr0_wvec_const", rf_wvec, 32'hA5A5_0000);
        idle();
        step();
        step();

        // write then immediate read: forwarded
        set_req(1, 1'b1, 1'b1, 3'd1, 16'h1234);
        step();
        set_req(1, 1'b1, 1'b0, 3'd1, 16'h0);
        step();
        check("fwd_read_const", {16'd0, rsp1_data}, 32'h1234);
        idle();
        step();
        step();
        set_req(1, 1'b1, 1'b0, 3'd1, 16'h0);
        step();
        check("late_read_const", {16'd0, rsp1_data}, 32'h1234);

        // read of the other entry right after a write
        set_req(0, 1'b1, 1'b1, 3'd1, 16'h5678);
        idle();
        v[0] = 1'b1;
        step();
        set_req(0, 1'b1, 1'b0, 3'd0, 16'h0);
        step();
        check("other_entry_const", {16'd0, rsp0_data}, 32'hA5A5);

        // continuous contention
        set_req(0, 1'b1, 1'b0, 3'd0, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd1, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            gseq.push_back(last_g);
        end
        for (int i = 1; i < 6; i++)
            check("alternate", gseq[i], 1 - gseq[i-1]);
        idle();
        step();

        // out-of-range read and write
        set_req(0, 1'b1, 1'b0, 3'd5, 16'h0);
        step();
        set_req(0, 1'b1, 1'b1, 3'd7, 16'hFFFF);
        step();
        check("oor_wvec_const", rf_wvec, 32'hA5A5_5678);
        idle();
        step();

        // reset in the cycle after a read accept
        set_req(1, 1'b1, 1'b0, 3'd0, 16'h0);
        step();
        idle();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("mid_rst_rsp1_data", {16'd0, rsp1_data}, 32'd0);
        check("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("mid_rst_wvec", rf_wvec, 32'd0);
        check("mid_rst_raddr", {29'd0, rf_raddr}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        set_req(0, 1'b1, 1'b0, 3'd1, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd0, 16'h0);
        step();
        check("post_rst_gnt", last_g, 0);
        idle();
        step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++)
                if (!v[r] || last_g == r)
                    rand_req(r);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
